pmsm_quad_encoder_rx: RTL and testbench

- Receive side of the rotor-position interface: decodes incremental quadrature encoder signals (A, B, index Z) from the PMSM shaft.
- Produces a wrapped mechanical position count, a rotation direction, and a windowed speed estimate for the commutation/SVPWM controller.
- Sits between the motor (or motor model) encoder pins and the control loop, in the same clock domain as the SVPWM generator.

---
 rtl/pmsm_enc_pkg.sv | 58 +++++
 rtl/pmsm_quad_encoder_rx_enc_input_filter.sv | 61 ++++++
 rtl/pmsm_quad_encoder_rx.sv | 163 ++++++++++++++++
 tb/tb_pmsm_quad_encoder_rx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pmsm_enc_pkg.sv
// Shared types and helpers for the quadrature encoder receiver.
package pmsm_enc_pkg;

    // Gray-coded {A,B} levels, forward order 00 -> 01 -> 11 -> 10 -> 00
    typedef enum logic [1:0] {
        AB_00 = 2'b00,
        AB_01 = 2'b01,
        AB_11 = 2'b11,
        AB_10 = 2'b10
    } ab_state_t;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_FWD  = 2'd1,
        STEP_REV  = 2'd2,
        STEP_ILL  = 2'd3
    } step_t;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    localparam logic signed [15:0] SPEED_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SPEED_MIN = 16'sh8000;

    // Wide enough for FILT_LEN up to 15
    localparam int FILT_CNT_W = 4;

    function automatic ab_state_t ab_fwd_of(ab_state_t s);
        ab_state_t n;
        case (s)
            AB_00:   n = AB_01;
            AB_01:   n = AB_11;
            AB_11:   n = AB_10;
            default: n = AB_00;
        endcase
        return n;
    endfunction

    function automatic step_t dec_step(ab_state_t prev, ab_state_t curr);
        step_t s;
        if (prev == curr)
            s = STEP_NONE;
        else if ((prev ^ curr) == 2'b11)
            s = STEP_ILL;
        else if (curr == ab_fwd_of(prev))
            s = STEP_FWD;
        else
            s = STEP_REV;
        return s;
    endfunction

    function automatic logic signed [15:0] sat_speed(logic signed [16:0] v);
        if (v[16] != v[15])
            return v[16] ? SPEED_MIN : SPEED_MAX;
        return v[15:0];
    endfunction

endpackage

// File: rtl/pmsm_quad_encoder_rx_enc_input_filter.sv
// Two-flop synchroniser followed by a stability filter for one encoder pin.
// After reset the filter spends three cycles tracking the synchronised level
// directly, so the pin level at release never shows up as an edge.
module enc_input_filter
    import pmsm_enc_pkg::*;
#(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_din,
    output logic o_dout,
    output logic o_ready
);

    localparam logic [FILT_CNT_W-1:0] FILT_LAST = FILT_CNT_W'(FILT_LEN - 1);

    logic [1:0]            r_sync;
    logic [1:0]            r_prime;
    logic [FILT_CNT_W-1:0] r_cnt;
    logic                  r_filt;
    logic                  w_ready;
    logic                  w_disagree;

    assign w_ready    = (r_prime == 2'd3);
    assign w_disagree = r_sync[1] ^ r_filt;

    // Metastability synchroniser
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sync <= 2'b00;
        else
            r_sync <= {r_sync[0], i_din};
    end

    // Accept a new level only after FILT_LEN consecutive disagreeing cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prime <= 2'd0;
            r_cnt   <= '0;
            r_filt  <= 1'b0;
        end else if (!w_ready) begin
            r_prime <= r_prime + 2'd1;
            r_cnt   <= '0;
            r_filt  <= r_sync[1];
        end else if (w_disagree) begin
            if (r_cnt == FILT_LAST) begin
                r_cnt  <= '0;
                r_filt <= r_sync[1];
            end else begin
                r_cnt <= r_cnt + FILT_CNT_W'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign o_dout  = r_filt;
    assign o_ready = w_ready;

endmodule

// File: rtl/pmsm_quad_encoder_rx.sv
// Quadrature encoder receiver: x4 decode, wrapped position, index reset,
// direction, illegal-transition tracking and windowed speed.
//
// AB state | meaning
// ---------+-------------------------------
// AB_00    | A low,  B low
// AB_01    | A low,  B high (one step fwd of 00)
// AB_11    | A high, B high
// AB_10    | A high, B low  (one step rev of 00)
module pmsm_quad_encoder_rx
    import pmsm_enc_pkg::*;
#(
    parameter int POS_MAX      = 4095,
    parameter int FILT_LEN     = 3,
    parameter int SPEED_WINDOW = 2000,
    parameter int ERR_CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_enc_a,
    input  logic                 i_enc_b,
    input  logic                 i_enc_z,
    input  logic                 i_index_en,
    output logic [15:0]          o_position,
    output logic                 o_direction,
    output logic [15:0]          o_speed,
    output logic                 o_speed_valid,
    output logic                 o_index_seen,
    output logic                 o_err_illegal,
    output logic [ERR_CNT_W-1:0] o_err_count
);

    localparam logic [15:0] POS_LAST = 16'(POS_MAX);
    localparam int          WIN_W    = (SPEED_WINDOW > 2) ? $clog2(SPEED_WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SPEED_WINDOW - 1);

    logic w_a, w_b, w_z;
    logic w_rdy_a, w_rdy_b, w_rdy_z;

    enc_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .clk(clk), .rst_n(rst_n), .i_din(i_enc_a), .o_dout(w_a), .o_ready(w_rdy_a));
    enc_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .clk(clk), .rst_n(rst_n), .i_din(i_enc_b), .o_dout(w_b), .o_ready(w_rdy_b));
    enc_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_z (
        .clk(clk), .rst_n(rst_n), .i_din(i_enc_z), .o_dout(w_z), .o_ready(w_rdy_z));

    // r_ab_samp / r_z_samp register the filtered pins; the decoder compares
    // them against the previous accepted state one cycle later.
    ab_state_t r_ab_samp, r_ab_state, w_ab_next;
    logic      r_z_samp, r_z_prev, r_armed;
    step_t     w_step;
    logic      w_z_rise;

    // State register for the Gray decoder and index edge detector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ab_samp  <= AB_00;
            r_ab_state <= AB_00;
            r_z_samp   <= 1'b0;
            r_z_prev   <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_ab_samp  <= ab_state_t'({w_a, w_b});
            r_ab_state <= w_ab_next;
            r_z_samp   <= w_z;
            r_z_prev   <= r_armed ? r_z_samp : w_z;
            r_armed    <= w_rdy_a & w_rdy_b & w_rdy_z;
        end
    end

    // Next state: follow the sampled AB; until armed, preload from the filters
    always_comb begin
        w_ab_next = r_ab_samp;
        if (!r_armed)
            w_ab_next = ab_state_t'({w_a, w_b});
    end

    // Decoder outputs: step classification and index rising edge
    always_comb begin
        w_step   = STEP_NONE;
        w_z_rise = 1'b0;
        if (r_armed) begin
            w_step   = dec_step(r_ab_state, r_ab_samp);
            w_z_rise = r_z_samp & ~r_z_prev;
        end
    end

    logic [15:0]          r_position;
    logic                 r_direction;
    logic                 r_index_seen;
    logic                 r_err_illegal;
    logic [ERR_CNT_W-1:0] r_err_count;

    // Position, direction, index and illegal-transition bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_position    <= 16'd0;
            r_direction   <= DIR_FWD;
            r_index_seen  <= 1'b0;
            r_err_illegal <= 1'b0;
            r_err_count   <= '0;
        end else begin
            r_err_illegal <= (w_step == STEP_ILL);
            if (w_step == STEP_ILL && r_err_count != '1)
                r_err_count <= r_err_count + ERR_CNT_W'(1);
            if (w_step == STEP_FWD)
                r_direction <= DIR_FWD;
            else if (w_step == STEP_REV)
                r_direction <= DIR_REV;
            if (w_z_rise)
                r_index_seen <= 1'b1;
            // Index takes priority over a coincident count step
            if (w_z_rise && i_index_en)
                r_position <= 16'd0;
            else if (w_step == STEP_FWD)
                r_position <= (r_position == POS_LAST) ? 16'd0 : r_position + 16'd1;
            else if (w_step == STEP_REV)
                r_position <= (r_position == 16'd0) ? POS_LAST : r_position - 16'd1;
        end
    end

    logic signed [16:0] r_acc, w_acc_next;
    logic [WIN_W-1:0]   r_win;
    logic signed [15:0] r_speed;
    logic               r_speed_valid;

    // Net step count including this cycle's step
    always_comb begin
        w_acc_next = r_acc;
        if (w_step == STEP_FWD)
            w_acc_next = r_acc + 17'sd1;
        else if (w_step == STEP_REV)
            w_acc_next = r_acc - 17'sd1;
    end

    // Speed window: publish and clear the accumulator at the window end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc         <= '0;
            r_win         <= '0;
            r_speed       <= '0;
            r_speed_valid <= 1'b0;
        end else if (r_win == WIN_LAST) begin
            r_acc         <= '0;
            r_win         <= '0;
            r_speed       <= sat_speed(w_acc_next);
            r_speed_valid <= 1'b1;
        end else begin
            r_acc         <= w_acc_next;
            r_win         <= r_win + WIN_W'(1);
            r_speed_valid <= 1'b0;
        end
    end

    assign o_position    = r_position;
    assign o_direction   = r_direction;
    assign o_speed       = r_speed;
    assign o_speed_valid = r_speed_valid;
    assign o_index_seen  = r_index_seen;
    assign o_err_illegal = r_err_illegal;
    assign o_err_count   = r_err_count;

endmodule

// File: tb/tb_pmsm_quad_encoder_rx.sv
// Directed bench for pmsm_quad_encoder_rx: a default instance plus a
// POS_MAX=15 instance sharing the same encoder pins for wrap checks.
module tb_pmsm_quad_encoder_rx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enc_a = 1'b0, enc_b = 1'b0, enc_z = 1'b0, index_en = 1'b0;

    logic [15:0] position, speed, w_position, w_speed;
    logic        direction, speed_valid, index_seen, err_illegal;
    logic        w_direction, w_speed_valid, w_index_seen, w_err_illegal;
    logic [7:0]  err_count, w_err_count;

    pmsm_quad_encoder_rx u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_enc_a(enc_a), .i_enc_b(enc_b), .i_enc_z(enc_z), .i_index_en(index_en),
        .o_position(position), .o_direction(direction), .o_speed(speed),
        .o_speed_valid(speed_valid), .o_index_seen(index_seen),
        .o_err_illegal(err_illegal), .o_err_count(err_count));

    pmsm_quad_encoder_rx #(.POS_MAX(15)) u_dut_w (
        .clk(clk), .rst_n(rst_n),
        .i_enc_a(enc_a), .i_enc_b(enc_b), .i_enc_z(enc_z), .i_index_en(index_en),
        .o_position(w_position), .o_direction(w_direction), .o_speed(w_speed),
        .o_speed_valid(w_speed_valid), .o_index_seen(w_index_seen),
        .o_err_illegal(w_err_illegal), .o_err_count(w_err_count));

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Cycle counter since reset release and output-pulse monitors
    int          cyc;
    int          ill_pulses = 0;
    int          v_cyc[$];
    logic [15:0] v_spd[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (err_illegal) ill_pulses++;
        if (speed_valid) begin
            v_cyc.push_back(cyc);
            v_spd.push_back(speed);
        end
    end

    logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    int idx = 0;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        enc_a = 1'b0; enc_b = 1'b0; enc_z = 1'b0;
        idx = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    task automatic step(input bit fwd, input int hold);
        idx = fwd ? (idx + 1) % 4 : (idx + 3) % 4;
        @(posedge clk); #1;
        {enc_a, enc_b} = gray[idx];
        repeat (hold) @(posedge clk);
    endtask

    task automatic check_reset_vals(string pfx);
        check_eq({pfx, "_pos"},   position,    16'd0);
        check_eq({pfx, "_dir"},   direction,   1'b1);
        check_eq({pfx, "_speed"}, speed,       16'd0);
        check_eq({pfx, "_valid"}, speed_valid, 1'b0);
        check_eq({pfx, "_idx"},   index_seen,  1'b0);
        check_eq({pfx, "_ill"},   err_illegal, 1'b0);
        check_eq({pfx, "_errc"},  err_count,   8'd0);
    endtask

    int n;
    int base;
    int vbase;
    int guard;

    initial begin
        // 1: reset values, latency, 8 forward steps
        do_reset();
        @(negedge clk);
        check_reset_vals("rst");
        check_eq("rst_wpos", w_position, 16'd0);

        idx = 1;
        @(posedge clk); #1;
        {enc_a, enc_b} = gray[idx];
        @(posedge clk);
        n = 0;
        while (position == 16'd0 && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check_eq("latency", n, 6);
        repeat (7) step(1'b1, 10);
        @(negedge clk);
        check_eq("fwd8_pos", position, 16'd8);
        check_eq("fwd8_dir", direction, 1'b1);
        check_eq("fwd8_errc", err_count, 8'd0);
        check_eq("fwd8_wpos", w_position, 16'd8);

        // 2: wrap at POS_MAX=15 in both directions
        repeat (7) step(1'b1, 10);
        @(negedge clk);
        check_eq("w15_pos", w_position, 16'd15);
        step(1'b1, 10);
        @(negedge clk);
        check_eq("wrap_fwd", w_position, 16'd0);
        check_eq("nowrap_big", position, 16'd16);
        step(1'b0, 10);
        @(negedge clk);
        check_eq("wrap_rev", w_position, 16'd15);
        check_eq("wrap_rev_dir", w_direction, 1'b0);
        check_eq("rev_pos", position, 16'd15);
        check_eq("rev_dir", direction, 1'b0);
        step(1'b1, 10);
        @(negedge clk);
        check_eq("back_pos", position, 16'd16);

        // 3: illegal 00 <-> 11 transitions, saturation
        base = ill_pulses;
        @(posedge clk); #1;
        {enc_a, enc_b} = 2'b11;
        repeat (15) @(posedge clk);
        @(negedge clk);
        check_eq("ill_pulse", ill_pulses - base, 1);
        check_eq("ill_errc1", err_count, 8'd1);
        check_eq("ill_pos", position, 16'd16);
        for (int i = 2; i <= 300; i++) begin
            @(posedge clk); #1;
            {enc_a, enc_b} = (i % 2 == 1) ? 2'b11 : 2'b00;
            repeat (8) @(posedge clk);
        end
        repeat (8) @(posedge clk);
        @(negedge clk);
        check_eq("ill_pulses300", ill_pulses - base, 300);
        check_eq("ill_sat", err_count, 8'hFF);
        check_eq("ill_pos300", position, 16'd16);
        idx = 0;

        // 4: two-cycle glitch on A is rejected
        base = ill_pulses;
        @(posedge clk); #1;
        enc_a = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        enc_a = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check_eq("glitch_pos", position, 16'd16);
        check_eq("glitch_ill", ill_pulses - base, 0);
        check_eq("glitch_dir", direction, 1'b1);

        // 5: index with coincident forward step
        do_reset();
        repeat (37) step(1'b1, 10);
        @(negedge clk);
        check_eq("pre_idx_pos", position, 16'd37);
        check_eq("pre_idx_seen", index_seen, 1'b0);
        index_en = 1'b1;
        idx = (idx + 1) % 4;
        @(posedge clk); #1;
        {enc_a, enc_b} = gray[idx];
        enc_z = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_eq("idx_pos", position, 16'd0);
        check_eq("idx_seen", index_seen, 1'b1);
        @(posedge clk); #1;
        enc_z = 1'b0;
        repeat (10) @(posedge clk);
        repeat (37) step(1'b1, 10);
        index_en = 1'b0;
        idx = (idx + 1) % 4;
        @(posedge clk); #1;
        {enc_a, enc_b} = gray[idx];
        enc_z = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_eq("noidx_pos", position, 16'd38);
        check_eq("noidx_seen", index_seen, 1'b1);
        @(posedge clk); #1;
        enc_z = 1'b0;

        // 6: speed windows and reset mid-window
        do_reset();
        vbase = v_cyc.size();
        repeat (50) step(1'b1, 10);
        guard = 0;
        while (cyc < 2005 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check_eq("win1_timeout", guard < 5000, 1'b1);
        check_eq("win1_pulses", v_cyc.size() - vbase, 1);
        if (v_cyc.size() > vbase) begin
            check_eq("win1_cycle", v_cyc[vbase], 2000);
            check_eq("win1_speed", v_spd[vbase], 16'd50);
        end
        repeat (20) step(1'b0, 10);
        guard = 0;
        while (cyc < 4005 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check_eq("win2_timeout", guard < 5000, 1'b1);
        check_eq("win2_pulses", v_cyc.size() - vbase, 2);
        if (v_cyc.size() > vbase + 1) begin
            check_eq("win2_cycle", v_cyc[vbase + 1], 4000);
            check_eq("win2_speed", v_spd[vbase + 1], 16'hFFEC);
        end
        check_eq("win2_dir", direction, 1'b0);
        repeat (5) step(1'b1, 10);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        #5;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
